// File: rtl/ram_sp_param_init_if.sv
// ram_sp_param_init_if: access bus for the single-port RAM with init sweep.
//   i_clear      : request to re-run the init sweep (honoured only when not busy)
//   i_address    : shared read/write address
//   i_data_in    : write data
//   i_write_en   : write strobe
//   i_byte_en    : per-byte write mask, bit k covers data bits [8k+7:8k]
//   i_read_en    : read strobe
//   o_data_out   : read data
//   o_read_valid : o_data_out holds valid data for the current request
//   o_busy       : init sweep in progress, user accesses ignored
// Signal prefixes are from the RAM's point of view (slave modport).
interface ram_sp_param_init_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                    i_clear;
  logic [ADDR_WIDTH-1:0]   i_address;
  logic [DATA_WIDTH-1:0]   i_data_in;
  logic                    i_write_en;
  logic [DATA_WIDTH/8-1:0] i_byte_en;
  logic                    i_read_en;
  logic [DATA_WIDTH-1:0]   o_data_out;
  logic                    o_read_valid;
  logic                    o_busy;

  modport master (
    output i_clear, i_address, i_data_in, i_write_en, i_byte_en, i_read_en,
    input  o_data_out, o_read_valid, o_busy
  );

  modport slave (
    input  i_clear, i_address, i_data_in, i_write_en, i_byte_en, i_read_en,
    output o_data_out, o_read_valid, o_busy
  );
endinterface

// File: rtl/ram_sp_param_init.sv
// ram_sp_param_init: parametrised single-port RAM with byte-enabled synchronous write,
// combinational (READ_LATENCY=0) or registered (READ_LATENCY=1) read, and an init
// engine that sweeps INIT_VALUE into every location after reset or on i_clear.
//   i_clk   : clock, all state on rising edge
//   i_reset : asynchronous active-high reset, restarts the init sweep
//   bus     : slave side of ram_sp_param_init_if (address/data/strobes/status)
// Any READ_LATENCY other than 0 builds the registered read path.
module ram_sp_param_init #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           ADDR_WIDTH   = 4,
  parameter int unsigned           READ_LATENCY = 0,
  parameter int unsigned           WRITE_FIRST  = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic                 i_clk,
  input logic                 i_reset,
  ram_sp_param_init_if.slave  bus
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  logic                  r_state;
  logic                  w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  w_busy;
  logic                  w_last;
  logic                  w_user_we;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_merged;

  logic [DATA_WIDTH-1:0] r_mem [Depth];

  assign w_busy    = (r_state == ST_INIT);
  // Terminal compare keeps the counter at ADDR_WIDTH bits without overflow concerns.
  assign w_last    = (r_cnt == {ADDR_WIDTH{1'b1}});
  assign w_user_we = bus.i_write_en & ~w_busy;
  assign w_rd_word = r_mem[bus.i_address];

  // Old word with the enabled bytes replaced; used both for writing and write-first reads.
  always_comb begin
    w_merged = w_rd_word;
    for (int k = 0; k < NumBytes; k++) begin
      if (bus.i_byte_en[k]) begin
        w_merged[8*k +: 8] = bus.i_data_in[8*k +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.i_clear) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Storage has no reset; the sweep gives it defined contents.
  always_ff @(posedge i_clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= INIT_VALUE;
    end else if (w_user_we) begin
      r_mem[bus.i_address] <= w_merged;
    end
  end

  assign bus.o_busy = w_busy;

  if (READ_LATENCY == 0) begin : g_async_read
    assign bus.o_data_out   = w_busy ? '0 : w_rd_word;
    assign bus.o_read_valid = bus.i_read_en & ~w_busy;
  end else begin : g_sync_read
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rvalid;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_dout   <= '0;
        r_rvalid <= 1'b0;
      end else if (bus.i_read_en && !w_busy) begin
        r_rvalid <= 1'b1;
        r_dout   <= ((WRITE_FIRST != 0) && bus.i_write_en) ? w_merged : w_rd_word;
      end else begin
        r_rvalid <= 1'b0;
      end
    end

    assign bus.o_data_out   = r_dout;
    assign bus.o_read_valid = r_rvalid;
  end

endmodule

// File: doc/ram_sp_param_init.md
Name: ram_sp_param_init

Overview:
Parametrised single-port RAM with synchronous write, per-byte write enables and selectable read latency (0 = asynchronous, 1 = registered). It includes an initialisation engine that sweeps every location to a known value after reset or on request, so the RAM never returns X. It is the general-purpose storage primitive for small buffers and lookup tables, replacing the fixed 16 x 8 asynchronous-read RAM.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH locations.
READ_LATENCY, 0, 0 = combinational read, 1 = registered read; other values are illegal.
WRITE_FIRST, 1, READ_LATENCY=1 only: 1 = a read colliding with a write returns new data, 0 = returns old data.
INIT_VALUE, 0, DATA_WIDTH-bit value written to every location by the init sweep.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  single-cycle request to re-run the init sweep; honoured only when busy=0
address  input  ADDR_WIDTH  shared read/write address
data_in  input  DATA_WIDTH  write data
write_en  input  1  active-high write strobe
byte_en  input  DATA_WIDTH/8  per-byte write mask; bit k covers data bits [8k+7:8k]
read_en  input  1  active-high read strobe
data_out  output  DATA_WIDTH  read data
read_valid  output  1  data_out holds valid read data for the current request
busy  output  1  init sweep in progress; all user accesses ignored

Behaviour:
- FSM states: INIT (sweep) and READY. reset asserted -> INIT, sweep counter = 0, busy = 1, read_valid = 0, data_out register = 0. RAM array has no reset.
- INIT: each cycle writes INIT_VALUE to ram[counter] (all bytes) and increments the counter. The cycle that writes DEPTH-1 transitions to READY, so busy is high for exactly DEPTH cycles after reset release. write_en, read_en and clear are ignored in INIT.
- READY: clear=1 -> INIT with counter 0 on the next edge. A user write in the same cycle as clear is still performed, then overwritten by the sweep.
- Reset asserted mid-sweep aborts the sweep; after release the sweep restarts from address 0.
- Write (READY, write_en=1): on the rising edge, for each k with byte_en[k]=1, ram[address] byte k <= data_in byte k. Bytes with byte_en[k]=0 are unchanged. byte_en all-zero means no change.
- READ_LATENCY=0:
  - data_out = ram[address] combinationally when busy=0; data_out = 0 while busy=1.
  - read_valid = read_en & ~busy, combinational.
  - A write is visible on data_out immediately after the writing edge.
- READ_LATENCY=1:
  - On an edge where read_en=1 and busy=0, the data_out register is loaded and read_valid <= 1.
  - Otherwise read_valid <= 0 and data_out holds its last value.
  - Collision (read_en=1 and write_en=1 in the same cycle):
    - WRITE_FIRST=1: data_out gets the byte-merged new word (enabled bytes from data_in, other bytes from the old contents).
    - WRITE_FIRST=0: data_out gets the old contents.
- Address has full ADDR_WIDTH range, so there are no out-of-range accesses and no wrap logic beyond the sweep terminal count.
- Sweep counter is ADDR_WIDTH+1 bits wide or uses a terminal compare, so DEPTH-1 terminates correctly with no overflow.

Test Plan:
1. Reset for 2 cycles, release -> busy=1 for exactly 16 cycles (defaults). Then read all 16 addresses -> each returns 8'h00, read_valid=1, and no X is seen on data_out.
2. DATA_WIDTH=32, write 32'hDEADBEEF to addr 5 with byte_en=4'hF. Then write 32'h11223344 with byte_en=4'b0101 -> read addr 5 returns 32'hDE22BE44.
3. READ_LATENCY=1, WRITE_FIRST=1: a single cycle at addr 3 (old 8'hAA) with write_en=read_en=1, data_in=8'h55 -> next cycle data_out=8'h55, read_valid=1. The same stimulus with WRITE_FIRST=0 -> data_out=8'hAA. The following idle cycle -> read_valid=0 and data_out held.
4. READ_LATENCY=0: write 8'h3C to addr 9 on edge N -> data_out=8'h3C within the same cycle after edge N with read_en=1. Addr changed to 10 (contents 8'h00) -> data_out=8'h00 combinationally.
5. In READY, fill addrs 0-15 with 8'hF0+i, then pulse clear -> busy=1 for 16 cycles. During the sweep a write of 8'h77 to addr 2 and a read are ignored (read_valid=0). Afterwards all addrs read 8'h00.
6. Assert reset on sweep cycle 7 for 1 cycle -> busy stays 1. The sweep restarts at 0 and busy deasserts 16 cycles after reset release. read_valid stays 0 throughout.
